// File: rtl/spi_master_engine.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_engine
//  Description : Full-duplex SPI master shift engine. Accepts one word per
//                valid/ready handshake, drives SCLK/CS_n/MOSI (MSB first)
//                and returns the word sampled on MISO.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_engine #(
    parameter int BIT_WIDTH      = 32,
    parameter int SPI_CLK_DIVIDE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [BIT_WIDTH-1:0] tx_data,
    output logic                 rx_valid,
    output logic [BIT_WIDTH-1:0] rx_data,
    output logic                 busy,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 mosi,
    input  logic                 miso
);

    localparam int c_div_w  = (SPI_CLK_DIVIDE > 1) ? $clog2(SPI_CLK_DIVIDE) : 1;
    localparam int c_edge_w = $clog2(2 * BIT_WIDTH);

    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(SPI_CLK_DIVIDE - 1);
    localparam logic [c_edge_w-1:0] c_edge_last = c_edge_w'(2 * BIT_WIDTH - 1);

    localparam logic [1:0] MOSI_IDLE = 2'd0;
    localparam logic [1:0] START_TX  = 2'd1;
    localparam logic [1:0] TRANSMIT  = 2'd2;
    localparam logic [1:0] END_TX    = 2'd3;

    logic [1:0]           r_state;
    logic [c_div_w-1:0]   r_div_cnt;
    logic [c_edge_w-1:0]  r_edge_cnt;
    logic [BIT_WIDTH-1:0] r_tx_sr;
    logic [BIT_WIDTH-1:0] r_rx_sr;
    logic                 r_cpol;
    logic                 r_cpha;
    logic                 r_tx_ready;
    logic                 r_rx_valid;
    logic [BIT_WIDTH-1:0] r_rx_data;
    logic                 r_busy;
    logic                 r_sclk;
    logic                 r_cs_n;
    logic                 r_mosi;

    logic w_div_wrap;
    logic w_leading;
    logic w_last_edge;
    logic w_sample_edge;

    assign w_div_wrap    = (r_div_cnt == c_div_last);
    assign w_leading     = ~r_edge_cnt[0];
    assign w_last_edge   = (r_edge_cnt == c_edge_last);
    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges
    assign w_sample_edge = r_cpha ? ~w_leading : w_leading;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= MOSI_IDLE;
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_tx_ready <= 1'b1;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_busy     <= 1'b0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                MOSI_IDLE: begin
                    r_sclk     <= mode[1];
                    r_cs_n     <= 1'b1;
                    r_mosi     <= 1'b0;
                    r_tx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_div_cnt  <= '0;
                    r_edge_cnt <= '0;
                    if (tx_valid && r_tx_ready) begin
                        r_tx_sr    <= tx_data;
                        r_rx_sr    <= '0;
                        r_cpol     <= mode[1];
                        r_cpha     <= mode[0];
                        r_cs_n     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_tx_ready <= 1'b0;
                        r_state    <= START_TX;
                        if (!mode[0]) begin
                            r_mosi <= tx_data[BIT_WIDTH-1];
                        end
                    end
                end

                START_TX: begin
                    r_sclk <= r_cpol;
                    if (w_div_wrap) begin
                        r_div_cnt <= '0;
                        r_state   <= TRANSMIT;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end

                TRANSMIT: begin
                    if (w_div_wrap) begin
                        r_div_cnt <= '0;
                        r_sclk    <= ~r_sclk;
                        if (w_sample_edge) begin
                            r_rx_sr <= {r_rx_sr[BIT_WIDTH-2:0], miso};
                        end else if (r_cpha) begin
                            r_mosi  <= r_tx_sr[BIT_WIDTH-1];
                            r_tx_sr <= r_tx_sr << 1;
                        end else if (!w_last_edge) begin
                            // MSB already went out at START_TX entry
                            r_mosi  <= r_tx_sr[BIT_WIDTH-2];
                            r_tx_sr <= r_tx_sr << 1;
                        end
                        if (w_last_edge) begin
                            r_edge_cnt <= '0;
                            r_state    <= END_TX;
                        end else begin
                            r_edge_cnt <= r_edge_cnt + 1'b1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end

                END_TX: begin
                    if (w_div_wrap) begin
                        r_div_cnt  <= '0;
                        r_cs_n     <= 1'b1;
                        r_rx_data  <= r_rx_sr;
                        r_rx_valid <= 1'b1;
                        r_mosi     <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= MOSI_IDLE;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= MOSI_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = r_tx_ready;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign busy     = r_busy;
    assign sclk     = r_sclk;
    assign cs_n     = r_cs_n;
    assign mosi     = r_mosi;

endmodule
`default_nettype wire
